// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU and its built-in self-test sequencer.
//   - ALU opcode constants
//   - bit positions of the ALU flags inside a 3-bit flag vector
//   - the self-test vector record and a helper to build one
//   - the sequencer FSM state encoding
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;
    localparam logic [4:0] OP_AND = 5'b00010;
    localparam logic [4:0] OP_OR  = 5'b00011;
    localparam logic [4:0] OP_SLL = 5'b00100;
    localparam logic [4:0] OP_SRA = 5'b00101;

    // Flag vector layout is {isNotEqual, isLessThan, overflow}
    localparam int FLAG_NE = 2;
    localparam int FLAG_LT = 1;
    localparam int FLAG_OV = 0;

    typedef struct packed {
        logic [31:0] opA;
        logic [31:0] opB;
        logic [4:0]  opcode;
        logic [4:0]  shamt;
        logic [31:0] exp_result;
        logic [2:0]  exp_flags;
        logic [2:0]  flag_mask;
    } bist_vector_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_WAIT,
        ST_CHECK,
        ST_DONE
    } bist_state_t;

    function automatic bist_vector_t make_vector(
        input logic [31:0] op_a,
        input logic [31:0] op_b,
        input logic [4:0]  opcode,
        input logic [4:0]  shamt,
        input logic [31:0] exp_result,
        input logic [2:0]  exp_flags,
        input logic [2:0]  flag_mask
    );
        bist_vector_t v;
        v.opA        = op_a;
        v.opB        = op_b;
        v.opcode     = opcode;
        v.shamt      = shamt;
        v.exp_result = exp_result;
        v.exp_flags  = exp_flags;
        v.flag_mask  = flag_mask;
        return v;
    endfunction

endpackage

// File: rtl/alu_bist_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_bist_sequencer_if
// Bus between the self-test sequencer and the combinational ALU.
//   alu_operandA/B, alu_opcode, alu_shiftamt : sequencer -> ALU
//   alu_result, alu_isNotEqual, alu_isLessThan, alu_overflow : ALU -> sequencer
// master = sequencer side, slave = ALU side.
// ---------------------------------------------------------------------------
interface alu_bist_sequencer_if;

    logic [31:0] alu_operandA;
    logic [31:0] alu_operandB;
    logic [4:0]  alu_opcode;
    logic [4:0]  alu_shiftamt;
    logic [31:0] alu_result;
    logic        alu_isNotEqual;
    logic        alu_isLessThan;
    logic        alu_overflow;

    modport master (
        output alu_operandA,
        output alu_operandB,
        output alu_opcode,
        output alu_shiftamt,
        input  alu_result,
        input  alu_isNotEqual,
        input  alu_isLessThan,
        input  alu_overflow
    );

    modport slave (
        input  alu_operandA,
        input  alu_operandB,
        input  alu_opcode,
        input  alu_shiftamt,
        output alu_result,
        output alu_isNotEqual,
        output alu_isLessThan,
        output alu_overflow
    );

endinterface

// File: rtl/alu_bist_vector_rom.sv
// ---------------------------------------------------------------------------
// alu_bist_vector_rom
// Combinational lookup of the ALU self-test vectors.
//   index : vector number (IDX_W bits)
//   vec   : operands, opcode, shift amount, expected result/flags, flag mask
// Indices past the last stored entry return an all-zero vector (ADD 0+0 with
// no flags checked), which any working ALU passes.
// ---------------------------------------------------------------------------
module alu_bist_vector_rom
    import alu_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic [IDX_W-1:0] index,
    output bist_vector_t     vec
);

    logic [31:0] idx_ext;

    assign idx_ext = 32'(index);

    // Flags are listed in full; the mask picks which ones the check uses.
    // Shift and logic ops leave flags unchecked because the ALU only defines
    // them for add/subtract.
    always_comb begin
        vec = '0;
        case (idx_ext)
            32'd0:  vec = make_vector(32'h000000AA, 32'h11111100, OP_ADD, 5'd0,  32'h111111AA, 3'b110, 3'b001);
            32'd1:  vec = make_vector(32'h76543210, 32'h12345678, OP_SUB, 5'd0,  32'h641FDB98, 3'b100, 3'b111);
            32'd2:  vec = make_vector(32'h00000001, 32'h00000000, OP_SLL, 5'd4,  32'h00000010, 3'b100, 3'b000);
            32'd3:  vec = make_vector(32'h80000000, 32'h00000000, OP_SRA, 5'd4,  32'hF8000000, 3'b110, 3'b000);
            32'd4:  vec = make_vector(32'h80000000, 32'h00000001, OP_SUB, 5'd0,  32'h7FFFFFFF, 3'b111, 3'b111);
            32'd5:  vec = make_vector(32'hFFFFFFFF, 32'h0000AAAA, OP_AND, 5'd0,  32'h0000AAAA, 3'b110, 3'b000);
            32'd6:  vec = make_vector(32'h0F0F0000, 32'h0000F0F0, OP_OR,  5'd0,  32'h0F0FF0F0, 3'b100, 3'b000);
            32'd7:  vec = make_vector(32'h7FFFFFFF, 32'h00000001, OP_ADD, 5'd0,  32'h80000000, 3'b101, 3'b001);
            32'd8:  vec = make_vector(32'h00000005, 32'h00000005, OP_SUB, 5'd0,  32'h00000000, 3'b000, 3'b111);
            32'd9:  vec = make_vector(32'h00000003, 32'h00000007, OP_SUB, 5'd0,  32'hFFFFFFFC, 3'b110, 3'b111);
            32'd10: vec = make_vector(32'hFFFFFFFF, 32'h00000001, OP_ADD, 5'd0,  32'h00000000, 3'b110, 3'b001);
            32'd11: vec = make_vector(32'hFFFFFFFF, 32'h00000000, OP_SLL, 5'd31, 32'h80000000, 3'b110, 3'b000);
            32'd12: vec = make_vector(32'h40000000, 32'h00000000, OP_SRA, 5'd30, 32'h00000001, 3'b100, 3'b000);
            32'd13: vec = make_vector(32'h7FFFFFFF, 32'hFFFFFFFF, OP_SUB, 5'd0,  32'h80000000, 3'b101, 3'b111);
            32'd14: vec = make_vector(32'h80000000, 32'h80000000, OP_ADD, 5'd0,  32'h00000000, 3'b001, 3'b001);
            32'd15: vec = make_vector(32'h12345678, 32'hF0F0F0F0, OP_AND, 5'd0,  32'h10305070, 3'b100, 3'b000);
            default: vec = '0;
        endcase
    end

endmodule

// File: rtl/alu_bist_sequencer.sv
// ---------------------------------------------------------------------------
// alu_bist_sequencer
// Built-in self-test initiator for the combinational ALU. Replays the vector
// ROM one entry at a time, lets the ALU settle, then compares result and
// masked flags against the expected values.
//   clock, reset_n : rising-edge clock, asynchronous active-low reset
//   start          : begin a run (honoured only in IDLE or DONE)
//   abort          : synchronous return to IDLE, wins over start
//   alu            : master side of the ALU bus (drive operands, read result)
//   busy           : run in progress
//   done           : run complete, held until the next start or abort
//   pass           : valid with done, 1 when no vector failed
//   error_count    : saturating count of failing vectors
//   fail_index     : index of the first failing vector
// ---------------------------------------------------------------------------
module alu_bist_sequencer
    import alu_pkg::*;
#(
    parameter int NUM_VECTORS   = 16,
    parameter int SETTLE_CYCLES = 1,
    parameter int ERR_W         = 8,
    localparam int IDX_W = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 abort,
    alu_bist_sequencer_if.master alu,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_W-1:0]     error_count,
    output logic [IDX_W-1:0]     fail_index
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [IDX_W-1:0] LAST_INDEX = IDX_W'(NUM_VECTORS - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

    bist_state_t      state;
    logic [IDX_W-1:0] index;
    logic [CNT_W-1:0] wait_cnt;
    bist_vector_t     rom_vec;
    logic [2:0]       flags_obs;
    logic             vec_fail;

    alu_bist_vector_rom #(
        .IDX_W (IDX_W)
    ) u_rom (
        .index (index),
        .vec   (rom_vec)
    );

    // index is stable from DRIVE through CHECK, so the ROM output seen in
    // CHECK is the same record that was driven onto the ALU.
    always_comb begin
        flags_obs          = 3'b000;
        flags_obs[FLAG_NE] = alu.alu_isNotEqual;
        flags_obs[FLAG_LT] = alu.alu_isLessThan;
        flags_obs[FLAG_OV] = alu.alu_overflow;
    end

    assign vec_fail = (alu.alu_result != rom_vec.exp_result) ||
                      (((flags_obs ^ rom_vec.exp_flags) & rom_vec.flag_mask) != 3'b000);

    // Single sequencer FSM with all outputs registered. Abort is checked
    // ahead of the state case so it beats a simultaneous start. On entry to
    // DONE busy drops at once, while done/pass follow one cycle later so that
    // pass sees the error count including the last vector.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state            <= ST_IDLE;
            index            <= '0;
            wait_cnt         <= '0;
            error_count      <= '0;
            fail_index       <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            alu.alu_operandA <= '0;
            alu.alu_operandB <= '0;
            alu.alu_opcode   <= '0;
            alu.alu_shiftamt <= '0;
        end else if (abort) begin
            state            <= ST_IDLE;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            alu.alu_operandA <= '0;
            alu.alu_operandB <= '0;
            alu.alu_opcode   <= '0;
            alu.alu_shiftamt <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state       <= ST_DRIVE;
                        index       <= '0;
                        error_count <= '0;
                        fail_index  <= '0;
                        pass        <= 1'b0;
                        done        <= 1'b0;
                        busy        <= 1'b1;
                    end else if (state == ST_DONE) begin
                        done <= 1'b1;
                        pass <= (error_count == '0);
                    end
                end
                ST_DRIVE: begin
                    alu.alu_operandA <= rom_vec.opA;
                    alu.alu_operandB <= rom_vec.opB;
                    alu.alu_opcode   <= rom_vec.opcode;
                    alu.alu_shiftamt <= rom_vec.shamt;
                    wait_cnt         <= SETTLE_LOAD;
                    state            <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (wait_cnt == '0) begin
                        state <= ST_CHECK;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                ST_CHECK: begin
                    // error_count is still zero exactly when this is the first failure
                    if (vec_fail) begin
                        if (error_count != ERR_MAX) begin
                            error_count <= error_count + 1'b1;
                        end
                        if (error_count == '0) begin
                            fail_index <= index;
                        end
                    end
                    if (index == LAST_INDEX) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                    end else begin
                        index <= index + 1'b1;
                        state <= ST_DRIVE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_bist_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_bist_sequencer
// Self-checking bench for alu_bist_sequencer. A behavioural ALU with
// selectable faults answers the sequencer; expected drive vectors and run
// summaries are queued when a run is started and compared as the DUT
// produces them. A second instance with ERR_W=2 sees a stuck ALU result.
// ---------------------------------------------------------------------------
module tb_alu_bist_sequencer;
    import alu_pkg::*;

    localparam int N      = 16;
    localparam int SETTLE = 1;
    localparam int P      = 2 + SETTLE;

    // Fault modes of the behavioural ALU
    localparam int F_NONE  = 0;
    localparam int F_FLIP3 = 1;
    localparam int F_OV0   = 2;
    localparam int F_STUCK = 3;

    // How a run is cut short
    localparam int STOP_NONE  = 0;
    localparam int STOP_ABORT = 1;
    localparam int STOP_RESET = 2;

    localparam logic [31:0] TB_A [N] = '{
        32'h000000AA, 32'h76543210, 32'h00000001, 32'h80000000,
        32'h80000000, 32'hFFFFFFFF, 32'h0F0F0000, 32'h7FFFFFFF,
        32'h00000005, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFF,
        32'h40000000, 32'h7FFFFFFF, 32'h80000000, 32'h12345678};
    localparam logic [31:0] TB_B [N] = '{
        32'h11111100, 32'h12345678, 32'h00000000, 32'h00000000,
        32'h00000001, 32'h0000AAAA, 32'h0000F0F0, 32'h00000001,
        32'h00000005, 32'h00000007, 32'h00000001, 32'h00000000,
        32'h00000000, 32'hFFFFFFFF, 32'h80000000, 32'hF0F0F0F0};
    localparam logic [4:0] TB_OP [N] = '{
        OP_ADD, OP_SUB, OP_SLL, OP_SRA, OP_SUB, OP_AND, OP_OR,  OP_ADD,
        OP_SUB, OP_SUB, OP_ADD, OP_SLL, OP_SRA, OP_SUB, OP_ADD, OP_AND};
    localparam logic [4:0] TB_SH [N] = '{
        5'd0, 5'd0, 5'd4, 5'd4, 5'd0, 5'd0, 5'd0, 5'd0,
        5'd0, 5'd0, 5'd0, 5'd31, 5'd30, 5'd0, 5'd0, 5'd0};
    localparam logic [2:0] TB_MASK [N] = '{
        3'b001, 3'b111, 3'b000, 3'b000, 3'b111, 3'b000, 3'b000, 3'b001,
        3'b111, 3'b111, 3'b001, 3'b000, 3'b000, 3'b111, 3'b001, 3'b000};

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  op;
        logic [4:0]  sh;
    } drive_t;

    typedef struct {
        int   err;
        int   first;
        logic pass;
    } summary_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic        busy, done, pass;
    logic [7:0]  error_count;
    logic [3:0]  fail_index;
    logic        busy2, done2, pass2;
    logic [1:0]  error_count2;
    logic [3:0]  fail_index2;

    int fault_mode;
    int cur_vec;
    int checks;
    int errors;

    drive_t   exp_q[$];
    summary_t sum_q[$];

    alu_bist_sequencer_if bus ();
    alu_bist_sequencer_if bus2 ();

    always #5 clock = ~clock;

    alu_bist_sequencer #(
        .NUM_VECTORS   (N),
        .SETTLE_CYCLES (SETTLE),
        .ERR_W         (8)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .abort       (abort),
        .alu         (bus),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .error_count (error_count),
        .fail_index  (fail_index)
    );

    alu_bist_sequencer #(
        .NUM_VECTORS   (N),
        .SETTLE_CYCLES (SETTLE),
        .ERR_W         (2)
    ) dut_sat (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .abort       (abort),
        .alu         (bus2),
        .busy        (busy2),
        .done        (done2),
        .pass        (pass2),
        .error_count (error_count2),
        .fail_index  (fail_index2)
    );

    // Reference ALU: returns {result, isNotEqual, isLessThan, overflow}
    function automatic logic [34:0] golden_alu(input logic [31:0] a, input logic [31:0] b,
                                               input logic [4:0] op, input logic [4:0] sh);
        logic [31:0] r;
        logic        ov;
        r  = 32'h0;
        ov = 1'b0;
        case (op)
            OP_ADD: begin r = a + b; ov = (a[31] == b[31]) && (r[31] != a[31]); end
            OP_SUB: begin r = a - b; ov = (a[31] != b[31]) && (r[31] != a[31]); end
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_SLL: r = a << sh;
            OP_SRA: r = $signed(a) >>> sh;
            default: r = 32'h0;
        endcase
        return {r, (a != b), ($signed(a) < $signed(b)), ov};
    endfunction

    function automatic logic [34:0] apply_fault(input int mode, input int vec, input logic [34:0] g);
        logic [34:0] o;
        o = g;
        case (mode)
            F_FLIP3: if (vec == 3) o[3] = ~o[3];
            F_OV0:   o[0] = 1'b0;
            F_STUCK: o[34:3] = 32'hDEADBEEF;
            default: o = g;
        endcase
        return o;
    endfunction

    always_comb begin
        logic [34:0] g;
        logic [34:0] o;
        g = golden_alu(bus.alu_operandA, bus.alu_operandB, bus.alu_opcode, bus.alu_shiftamt);
        o = apply_fault(fault_mode, cur_vec, g);
        bus.alu_result     = o[34:3];
        bus.alu_isNotEqual = o[2];
        bus.alu_isLessThan = o[1];
        bus.alu_overflow   = o[0];
    end

    always_comb begin
        logic [34:0] g2;
        g2 = golden_alu(bus2.alu_operandA, bus2.alu_operandB, bus2.alu_opcode, bus2.alu_shiftamt);
        bus2.alu_result     = 32'hDEADBEEF;
        bus2.alu_isNotEqual = g2[2];
        bus2.alu_isLessThan = g2[1];
        bus2.alu_overflow   = g2[0];
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // Expected error count / first failing index over vectors 0..limit-1
    task automatic compute_expected(input int mode, input int limit, input int err_max,
                                    output int err, output int first);
        logic [34:0] g;
        logic [34:0] o;
        logic        fail;
        err   = 0;
        first = 0;
        for (int i = 0; i < limit; i++) begin
            g    = golden_alu(TB_A[i], TB_B[i], TB_OP[i], TB_SH[i]);
            o    = apply_fault(mode, i, g);
            fail = (o[34:3] != g[34:3]) || (((o[2:0] ^ g[2:0]) & TB_MASK[i]) != 3'b000);
            if (fail) begin
                if (err == 0) first = i;
                if (err < err_max) err++;
            end
        end
    endtask

    task automatic applyStimulus(input int mode, input int stop_kind, input int stop_at,
                                 input int extra_start_at);
        int       k;
        int       busy_cycles;
        bit       got_done;
        bit       stopped;
        int       part_err;
        int       part_first;
        drive_t   d;
        summary_t s;

        fault_mode = mode;
        cur_vec    = 0;
        exp_q.delete();
        for (int i = 0; i < N; i++) begin
            d.a = TB_A[i];
            d.b = TB_B[i];
            d.op = TB_OP[i];
            d.sh = TB_SH[i];
            exp_q.push_back(d);
        end
        if (stop_kind == STOP_NONE) begin
            compute_expected(mode, N, 255, s.err, s.first);
            s.pass = (s.err == 0);
            sum_q.push_back(s);
        end

        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;

        k           = 0;
        busy_cycles = 0;
        got_done    = 1'b0;
        stopped     = 1'b0;
        while (k < 200 && !got_done && !stopped) begin
            if (k > 0) begin
                @(posedge clock);
                #1;
                start = 1'b0;
            end
            if (busy) busy_cycles++;
            if (k % P == 1) cur_vec = k / P;
            if (k % P == 2 && exp_q.size() > 0) begin
                d = exp_q.pop_front();
                checkOutput("drive_opA",   bus.alu_operandA, d.a);
                checkOutput("drive_opB",   bus.alu_operandB, d.b);
                checkOutput("drive_op",    bus.alu_opcode,   d.op);
                checkOutput("drive_shamt", bus.alu_shiftamt, d.sh);
            end
            if (done) begin
                got_done = 1'b1;
            end else begin
                if (k == extra_start_at) start = 1'b1;
                if (k == stop_at) begin
                    compute_expected(mode, k / P, 255, part_err, part_first);
                    if (stop_kind == STOP_ABORT) begin
                        abort = 1'b1;
                        @(posedge clock);
                        #1;
                        abort = 1'b0;
                        checkOutput("abort_busy",  busy, 0);
                        checkOutput("abort_done",  done, 0);
                        checkOutput("abort_pass",  pass, 0);
                        checkOutput("abort_opA",   bus.alu_operandA, 0);
                        checkOutput("abort_opB",   bus.alu_operandB, 0);
                        checkOutput("abort_op",    bus.alu_opcode, 0);
                        checkOutput("abort_shamt", bus.alu_shiftamt, 0);
                        checkOutput("abort_keep_err",   error_count, part_err);
                        checkOutput("abort_keep_index", fail_index, part_first);
                    end else begin
                        checkOutput("prereset_err",   error_count, part_err);
                        checkOutput("prereset_index", fail_index, part_first);
                        #2;
                        reset_n = 1'b0;
                        #1;
                        checkOutput("reset_busy",  busy, 0);
                        checkOutput("reset_done",  done, 0);
                        checkOutput("reset_pass",  pass, 0);
                        checkOutput("reset_err",   error_count, 0);
                        checkOutput("reset_index", fail_index, 0);
                        checkOutput("reset_opA",   bus.alu_operandA, 0);
                        checkOutput("reset_op",    bus.alu_opcode, 0);
                        @(negedge clock);
                        reset_n = 1'b1;
                    end
                    stopped = 1'b1;
                end
            end
            if (!got_done && !stopped) k++;
        end

        if (stop_kind == STOP_NONE) begin
            checkOutput("done_seen",     got_done, 1);
            checkOutput("done_edge",     k, P * N + 1);
            checkOutput("busy_cycles",   busy_cycles, P * N);
            checkOutput("vectors_left",  exp_q.size(), 0);
            checkOutput("done_busy_low", busy, 0);
            if (sum_q.size() > 0) begin
                s = sum_q.pop_front();
                checkOutput("err_count",  error_count, s.err);
                checkOutput("fail_index", fail_index, s.first);
                checkOutput("pass",       pass, s.pass);
            end
        end
        exp_q.delete();
    endtask

    initial begin
        int sat_err;
        int sat_first;

        checks     = 0;
        errors     = 0;
        fault_mode = F_NONE;
        cur_vec    = 0;
        reset_n    = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;

        repeat (2) @(posedge clock);
        #1;
        checkOutput("rst_busy",  busy, 0);
        checkOutput("rst_done",  done, 0);
        checkOutput("rst_pass",  pass, 0);
        checkOutput("rst_err",   error_count, 0);
        checkOutput("rst_index", fail_index, 0);
        checkOutput("rst_opA",   bus.alu_operandA, 0);
        checkOutput("rst_opB",   bus.alu_operandB, 0);
        checkOutput("rst_op",    bus.alu_opcode, 0);
        checkOutput("rst_shamt", bus.alu_shiftamt, 0);
        @(negedge clock);
        reset_n = 1'b1;

        // Golden ALU; the ERR_W=2 instance runs alongside against a stuck result
        $display("[TB] golden run");
        applyStimulus(F_NONE, STOP_NONE, -1, -1);
        compute_expected(F_STUCK, N, 3, sat_err, sat_first);
        checkOutput("sat_done",  done2, 1);
        checkOutput("sat_err",   error_count2, sat_err);
        checkOutput("sat_index", fail_index2, sat_first);
        checkOutput("sat_pass",  pass2, 0);

        $display("[TB] result flipped on vector 3");
        applyStimulus(F_FLIP3, STOP_NONE, -1, -1);

        $display("[TB] overflow flag stuck low");
        applyStimulus(F_OV0, STOP_NONE, -1, -1);

        $display("[TB] abort at cycle 10, then clean run");
        applyStimulus(F_STUCK, STOP_ABORT, 10, -1);
        applyStimulus(F_NONE, STOP_NONE, -1, -1);

        $display("[TB] start while busy, reset at cycle 20");
        applyStimulus(F_FLIP3, STOP_RESET, 20, 5);

        $display("[TB] start and abort together in IDLE");
        fault_mode = F_NONE;
        @(negedge clock);
        start = 1'b1;
        abort = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        abort = 1'b0;
        checkOutput("sa_busy", busy, 0);
        checkOutput("sa_done", done, 0);
        checkOutput("sa_opA",  bus.alu_operandA, 0);
        @(posedge clock);
        #1;
        checkOutput("sa_idle_hold", busy, 0);

        applyStimulus(F_NONE, STOP_NONE, -1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
